// File: rtl/lamp_sequence_monitor.sv
// lamp_sequence_monitor
//   Checks the one-hot lamp bus from the 4-lamp cyclic sequencer. It confirms
//   the RED->GREEN->YELLOW->BLUE cycle, counts completed laps, and raises
//   sticky error bits for illegal patterns, out-of-order steps and stuck lamps.
// Ports
//   clock       posedge system clock
//   reset       asynchronous active-high reset, clears all state
//   light[0:3]  lamp bus R,G,Y,B (RED=1000 GREEN=0100 YELLOW=0010 BLUE=0001)
//   clear       sync pulse, clears sticky error bits (a new error wins)
//   locked      1 while tracking a valid sequence
//   lap_count   completed laps (BLUE->RED while locked), wraps
//   err_illegal sticky: non-one-hot pattern while locked
//   err_order   sticky: legal but wrong next pattern while locked
//   err_stuck   sticky: pattern held more than STUCK_MAX samples
//   fault       combinational OR of the error bits
module lamp_sequence_monitor #(
  parameter int unsigned STUCK_MAX = 4,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [0:3]       light,
  input  logic             clear,
  output logic             locked,
  output logic [CNT_W-1:0] lap_count,
  output logic             err_illegal,
  output logic             err_order,
  output logic             err_stuck,
  output logic             fault
);

  localparam int unsigned HOLD_W = $clog2(STUCK_MAX + 2);
  localparam logic [HOLD_W-1:0] HOLD_SAT = HOLD_W'(STUCK_MAX + 1);
  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(STUCK_MAX);

  localparam logic [0:3] RED    = 4'b1000;
  localparam logic [0:3] GREEN  = 4'b0100;
  localparam logic [0:3] YELLOW = 4'b0010;
  localparam logic [0:3] BLUE   = 4'b0001;

  typedef enum logic {SYNC, LOCK} state_t;

  state_t            state, state_nxt;
  logic [0:3]        last, last_nxt;
  logic [HOLD_W-1:0] hold, hold_nxt, hold_inc;
  logic [CNT_W-1:0]  lap_nxt;
  logic [0:3]        next_pat;
  logic              locked_nxt;
  logic              new_ill, new_ord, new_stk;
  logic              ill_nxt, ord_nxt, stk_nxt;

  // State and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= SYNC;
      last        <= 4'b0000;
      hold        <= '0;
      lap_count   <= '0;
      locked      <= 1'b0;
      err_illegal <= 1'b0;
      err_order   <= 1'b0;
      err_stuck   <= 1'b0;
    end else begin
      state       <= state_nxt;
      last        <= last_nxt;
      hold        <= hold_nxt;
      lap_count   <= lap_nxt;
      locked      <= locked_nxt;
      err_illegal <= ill_nxt;
      err_order   <= ord_nxt;
      err_stuck   <= stk_nxt;
    end
  end

  // Next-state, counters and error detection
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    hold_nxt  = hold;
    lap_nxt   = lap_count;
    new_ill   = 1'b0;
    new_ord   = 1'b0;
    new_stk   = 1'b0;

    unique case (last)
      RED:     next_pat = GREEN;
      GREEN:   next_pat = YELLOW;
      YELLOW:  next_pat = BLUE;
      default: next_pat = RED;
    endcase

    hold_inc = (hold == HOLD_SAT) ? hold : hold + HOLD_W'(1);

    unique case (state)
      SYNC: begin
        if (light == RED) begin
          state_nxt = LOCK;
          last_nxt  = RED;
          hold_nxt  = HOLD_W'(1);
        end
      end
      LOCK: begin
        if (light == last) begin
          hold_nxt = hold_inc;
          if (hold_inc > HOLD_LIM) begin
            new_stk   = 1'b1;
            state_nxt = SYNC;
          end
        end else if (light == next_pat) begin
          last_nxt = light;
          hold_nxt = HOLD_W'(1);
          if (last == BLUE) lap_nxt = lap_count + CNT_W'(1);
        end else if (!$onehot(light)) begin
          new_ill   = 1'b1;
          state_nxt = SYNC;
        end else begin
          new_ord   = 1'b1;
          state_nxt = SYNC;
        end
      end
      default: state_nxt = SYNC;
    endcase

    // A fresh error on the clearing edge keeps its bit set
    ill_nxt    = (err_illegal & ~clear) | new_ill;
    ord_nxt    = (err_order   & ~clear) | new_ord;
    stk_nxt    = (err_stuck   & ~clear) | new_stk;
    locked_nxt = (state_nxt == LOCK);
  end

  assign fault = err_illegal | err_order | err_stuck;

endmodule

// File: tb/tb_lamp_sequence_monitor.sv
// Directed-vector scoreboard bench for lamp_sequence_monitor. Two instances
// share the stimulus: default lap width (8) and a 2-bit lap counter for wrap.
module tb_lamp_sequence_monitor;

  localparam logic [0:3] R = 4'b1000;
  localparam logic [0:3] G = 4'b0100;
  localparam logic [0:3] Y = 4'b0010;
  localparam logic [0:3] B = 4'b0001;

  typedef struct {
    string      nm;
    logic       lk;
    logic [7:0] lap;
    logic       ei;
    logic       eo;
    logic       es;
  } exp_t;

  logic       clock;
  logic       reset;
  logic [0:3] light;
  logic       clear;

  logic       locked_a, ei_a, eo_a, es_a, fault_a;
  logic [7:0] lap_a;
  logic       locked_b, ei_b, eo_b, es_b, fault_b;
  logic [1:0] lap_b;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  lamp_sequence_monitor #(.STUCK_MAX(4), .CNT_W(8)) dut_a (
    .clock(clock), .reset(reset), .light(light), .clear(clear),
    .locked(locked_a), .lap_count(lap_a), .err_illegal(ei_a),
    .err_order(eo_a), .err_stuck(es_a), .fault(fault_a)
  );

  lamp_sequence_monitor #(.STUCK_MAX(4), .CNT_W(2)) dut_b (
    .clock(clock), .reset(reset), .light(light), .clear(clear),
    .locked(locked_b), .lap_count(lap_b), .err_illegal(ei_b),
    .err_order(eo_b), .err_stuck(es_b), .fault(fault_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic compare(input exp_t e);
    logic ok;
    logic f;
    f  = e.ei | e.eo | e.es;
    ok = (locked_a === e.lk) && (lap_a === e.lap) && (ei_a === e.ei) &&
         (eo_a === e.eo) && (es_a === e.es) && (fault_a === f) &&
         (locked_b === e.lk) && (lap_b === e.lap[1:0]) && (ei_b === e.ei) &&
         (eo_b === e.eo) && (es_b === e.es) && (fault_b === f);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got a(lk=%b lap=%0d ei=%b eo=%b es=%b f=%b) b(lk=%b lap=%0d ei=%b eo=%b es=%b f=%b) want lk=%b lap=%0d/%0d ei=%b eo=%b es=%b f=%b",
               e.nm, locked_a, lap_a, ei_a, eo_a, es_a, fault_a,
               locked_b, lap_b, ei_b, eo_b, es_b, fault_b,
               e.lk, e.lap, e.lap[1:0], e.ei, e.eo, e.es, f);
    end
  endtask

  // Monitor: one output sample per clock, checked against the queued entry
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        compare(e);
      end
    end
  end

  // Drive one sample and queue the outputs expected after it is clocked in
  task automatic step(input string nm, input logic [0:3] l, input logic clr,
                      input logic lk, input int lap,
                      input logic ei, input logic eo, input logic es);
    exp_t e;
    @(posedge clock);
    #2;
    light = l;
    clear = clr;
    e.nm  = nm;
    e.lk  = lk;
    e.lap = 8'(lap);
    e.ei  = ei;
    e.eo  = eo;
    e.es  = es;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 20) begin
      @(posedge clock);
      n++;
    end
    #3;
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end
  endtask

  initial begin
    exp_t z;
    z.lk = 1'b0; z.lap = 8'd0; z.ei = 1'b0; z.eo = 1'b0; z.es = 1'b0;
    reset = 1'b0;
    light = 4'b0000;
    clear = 1'b0;
    #1 reset = 1'b1;
    #2;
    z.nm = "reset_async";
    compare(z);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    // 1: two full laps
    step("t1_r1", R, 0, 1, 0, 0, 0, 0);
    step("t1_g1", G, 0, 1, 0, 0, 0, 0);
    step("t1_y1", Y, 0, 1, 0, 0, 0, 0);
    step("t1_b1", B, 0, 1, 0, 0, 0, 0);
    step("t1_r2", R, 0, 1, 1, 0, 0, 0);
    step("t1_g2", G, 0, 1, 1, 0, 0, 0);
    step("t1_y2", Y, 0, 1, 1, 0, 0, 0);
    step("t1_b2", B, 0, 1, 1, 0, 0, 0);
    step("t1_r3", R, 0, 1, 2, 0, 0, 0);

    // 2: illegal pattern, then relock on RED
    step("t2_g",     G,       0, 1, 2, 0, 0, 0);
    step("t2_ill",   4'b1100, 0, 0, 2, 1, 0, 0);
    step("t2_relck", R,       0, 1, 2, 1, 0, 0);

    // 3: out-of-order step (after clearing the illegal bit)
    step("t3_clr", G, 1, 1, 2, 0, 0, 0);
    step("t3_y",   Y, 0, 1, 2, 0, 0, 0);
    step("t3_b",   B, 0, 1, 2, 0, 0, 0);
    step("t3_r",   R, 0, 1, 3, 0, 0, 0);
    step("t3_g",   G, 0, 1, 3, 0, 0, 0);
    step("t3_ord", B, 0, 0, 3, 0, 1, 0);

    // 4: RED held 4 samples is fine, 5 samples is stuck
    step("t4_r1c", R, 1, 1, 3, 0, 0, 0);
    step("t4_r2",  R, 0, 1, 3, 0, 0, 0);
    step("t4_r3",  R, 0, 1, 3, 0, 0, 0);
    step("t4_r4",  R, 0, 1, 3, 0, 0, 0);
    step("t4_g",   G, 0, 1, 3, 0, 0, 0);
    step("t4_y",   Y, 0, 1, 3, 0, 0, 0);
    step("t4_b",   B, 0, 1, 3, 0, 0, 0);
    step("t4_s1",  R, 0, 1, 4, 0, 0, 0);
    step("t4_s2",  R, 0, 1, 4, 0, 0, 0);
    step("t4_s3",  R, 0, 1, 4, 0, 0, 0);
    step("t4_s4",  R, 0, 1, 4, 0, 0, 0);
    step("t4_stk", R, 0, 0, 4, 0, 0, 1);
    step("t4_syg", G,       0, 0, 4, 0, 0, 1);
    step("t4_sy0", 4'b0000, 0, 0, 4, 0, 0, 1);
    step("t4_rlk", R,       0, 1, 4, 0, 0, 1);

    // 5: clear alone, then clear on the same edge as an order fault
    step("t5_clr",  G,       1, 1, 4, 0, 0, 0);
    step("t5_ill",  4'b0000, 0, 0, 4, 1, 0, 0);
    step("t5_r",    R,       0, 1, 4, 1, 0, 0);
    step("t5_g",    G,       0, 1, 4, 1, 0, 0);
    step("t5_ordc", R,       1, 0, 4, 0, 1, 0);

    // 6: more laps, 2-bit counter wraps 3->0 again
    step("t6_r",  R, 0, 1, 4, 0, 1, 0);
    for (int lap = 5; lap <= 8; lap++) begin
      step("t6_g", G, 0, 1, lap - 1, 0, 1, 0);
      step("t6_y", Y, 0, 1, lap - 1, 0, 1, 0);
      step("t6_b", B, 0, 1, lap - 1, 0, 1, 0);
      step("t6_r", R, 0, 1, lap,     0, 1, 0);
    end
    step("t6_g9", G, 0, 1, 8, 0, 1, 0);
    step("t6_y9", Y, 0, 1, 8, 0, 1, 0);
    drain();

    // Async reset mid-lap with no clock edge
    reset = 1'b1;
    #1;
    z.nm = "reset_midlap";
    compare(z);
    @(negedge clock);
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
